// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with PWM brightness,
// frame-synchronous input snapshot and leading-zero suppression.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10000,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clkin,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lzs_en,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIG_MAX = DW'(DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] SUB_MAX = '1;

    logic [PW-1:0]       r_pre;
    logic [BRIGHT_W-1:0] r_sub;
    logic [DW-1:0]       r_digit;
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_dp_snap;
    logic [DIGITS-1:0]   r_blank;
    logic                r_lzs;
    logic                r_loaded;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_slot_end;
    logic                w_boundary;
    logic                w_load;
    logic [3:0]          w_nib;
    logic [DIGITS-1:0]   w_hi_zero;
    logic                w_supp;
    logic                w_lit;
    logic [DIGITS-1:0]   w_an;

    function automatic logic [6:0] f_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign w_tick     = (r_pre == PRE_MAX);
    assign w_slot_end = w_tick && (r_sub == SUB_MAX);
    assign w_boundary = w_slot_end && (r_digit == DIG_MAX);
    assign w_load     = w_boundary || !r_loaded;
    assign w_nib      = r_value[{r_digit, 2'b00} +: 4];
    assign w_an       = ~(DIGITS'(1) << r_digit);

    // w_hi_zero[k]: snapshot nibbles k..DIGITS-1 are all zero
    always_comb begin
        logic acc;
        acc = 1'b1;
        w_hi_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc = acc && (r_value[4*k +: 4] == 4'h0);
            w_hi_zero[k] = acc;
        end
    end

    assign w_supp = r_lzs && (r_digit != '0) && w_hi_zero[r_digit];
    assign w_lit  = (r_sub != '0) && (r_sub <= brightness)
                    && !r_blank[r_digit] && !w_supp;

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_pre        <= '0;
            r_sub        <= '0;
            r_digit      <= '0;
            r_loaded     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_loaded     <= 1'b1;
            r_frame_done <= w_boundary;
            r_pre        <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick) begin
                r_sub <= r_sub + BRIGHT_W'(1);
            end
            if (w_slot_end) begin
                r_digit <= (r_digit == DIG_MAX) ? '0 : r_digit + DW'(1);
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_value   <= '0;
            r_dp_snap <= '0;
            r_blank   <= '0;
            r_lzs     <= 1'b0;
        end else if (w_load) begin
            r_value   <= value;
            r_dp_snap <= dp_in;
            r_blank   <= blank_mask;
            r_lzs     <= lzs_en;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset || !w_lit) begin
            r_an  <= '1;
            r_seg <= '1;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= f_glyph(w_nib);
            r_dp  <= ~r_dp_snap[r_digit];
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-level vector table with a
// per-digit scoreboard, plus boundary, reset and invariant sequences.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in, blank;
    logic        lzs;
    logic [1:0]  bright;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, fd;

    logic [3:0]  v1;
    logic        dp1, lzs1;
    logic [1:0]  bright1;
    logic        an1, dpo1, fd1;
    logic [6:0]  seg1;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .TICK_DIV(2), .BRIGHT_W(2)) dut (
        .clkin(clk), .reset(rst), .value(value), .dp_in(dp_in),
        .blank_mask(blank), .lzs_en(lzs), .brightness(bright),
        .an(an), .seg(seg), .dp(dp), .frame_done(fd)
    );

    seg7_scan_driver #(.DIGITS(1), .TICK_DIV(1), .BRIGHT_W(2)) dut1 (
        .clkin(clk), .reset(rst), .value(v1), .dp_in(dp1),
        .blank_mask(1'b0), .lzs_en(lzs1), .brightness(bright1),
        .an(an1), .seg(seg1), .dp(dpo1), .frame_done(fd1)
    );

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic [3:0]  blank;
        logic        lzs;
        logic [1:0]  bright;
        logic [3:0]  lit;
    } vec_t;

    typedef struct {
        int         cnt;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic [6:0] GLY [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    vec_t vecs[10];
    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    int         o_cnt [4];
    logic [6:0] o_seg [4];
    logic       o_dp  [4];
    int         o_bad;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_fd();
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (fd) got = 1'b1;
        end
        chk("fd_wait", int'(got), 1);
    endtask

    // Watch one 32-clock frame following a frame_done sample.
    task automatic obs_frame();
        logic [3:0] pat;
        bit found;
        o_bad = 0;
        for (int k = 0; k < 4; k++) begin
            o_cnt[k] = 0;
            o_seg[k] = 7'h7f;
            o_dp[k]  = 1'b1;
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (an == 4'hf) begin
                if (seg != 7'h7f || dp != 1'b1) o_bad++;
            end else begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    pat = ~(4'b0001 << k);
                    if (an == pat) begin
                        found = 1'b1;
                        if (o_cnt[k] > 0 && o_seg[k] != seg) o_bad++;
                        o_cnt[k]++;
                        o_seg[k] = seg;
                        o_dp[k]  = dp;
                    end
                end
                if (!found) o_bad++;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'h1A3F, 4'b0000, 4'b0000, 1'b0, 2'd3, 4'b1111};
        vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 2'd3, 4'b0011};
        vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3, 4'b0001};
        vecs[3] = '{16'h0050, 4'b0000, 4'b0000, 1'b0, 2'd3, 4'b1111};
        vecs[4] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b1111};
        vecs[5] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd1, 4'b1111};
        vecs[6] = '{16'h5678, 4'b0000, 4'b0100, 1'b0, 2'd3, 4'b1011};
        vecs[7] = '{16'h9BCD, 4'b0001, 4'b0000, 1'b0, 2'd3, 4'b1111};
        vecs[8] = '{16'h0E00, 4'b1010, 4'b0000, 1'b1, 2'd3, 4'b0111};
        vecs[9] = '{16'h8000, 4'b0000, 4'b1000, 1'b1, 2'd2, 4'b0111};

        rst = 1'b1;
        value = '0; dp_in = '0; blank = '0; lzs = 1'b0; bright = '0;
        v1 = '0; dp1 = 1'b0; lzs1 = 1'b0; bright1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'hf);
        chk("rst_seg", seg, 7'h7f);
        chk("rst_dp", dp, 1);
        chk("rst_fd", fd, 0);
        chk("rst_an1", an1, 1);
        rst = 1'b0;

        foreach (vecs[v]) begin
            exp_t e;
            value  = vecs[v].value;
            dp_in  = vecs[v].dp_in;
            blank  = vecs[v].blank;
            lzs    = vecs[v].lzs;
            bright = vecs[v].bright;
            for (int k = 0; k < 4; k++) begin
                logic on;
                on = vecs[v].lit[k] && (vecs[v].bright != 0);
                e.cnt = on ? 2 * int'(vecs[v].bright) : 0;
                e.seg = on ? GLY[vecs[v].value[4*k +: 4]] : 7'h7f;
                e.dp  = on ? ~vecs[v].dp_in[k] : 1'b1;
                sbq.push_back(e);
            end
            wait_fd();
            obs_frame();
            for (int k = 0; k < 4; k++) begin
                e = sbq.pop_front();
                chk($sformatf("v%0d_d%0d_cnt", v, k), o_cnt[k], e.cnt);
                chk($sformatf("v%0d_d%0d_seg", v, k), o_seg[k], e.seg);
                chk($sformatf("v%0d_d%0d_dp", v, k), o_dp[k], e.dp);
            end
            chk($sformatf("v%0d_pattern", v), o_bad, 0);
        end

        // Mid-frame value change must wait for the next boundary.
        begin
            int b1 = 0, b2 = 0, fb = 0;
            value = 16'h1111; dp_in = '0; blank = '0; lzs = 1'b0;
            bright = 2'd3;
            wait_fd();
            for (int i = 1; i <= 32; i++) begin
                if (i == 10) value = 16'h2222;
                @(negedge clk);
                if (an != 4'hf && seg != GLY[1]) b1++;
                if (fd != (i == 32)) fb++;
            end
            for (int i = 1; i <= 32; i++) begin
                @(negedge clk);
                if (an != 4'hf && seg != GLY[2]) b2++;
                if (fd != (i == 32)) fb++;
            end
            chk("snap_old_frame", b1, 0);
            chk("snap_new_frame", b2, 0);
            chk("fd_period32", fb, 0);
        end

        // Reset during digit 2, then restart latency.
        begin
            bit seen = 1'b0;
            int k;
            value = 16'h1A3F;
            wait_fd();
            for (int i = 0; i < 64 && !seen; i++) begin
                @(negedge clk);
                if (an == 4'b1011) seen = 1'b1;
            end
            chk("d2_seen", int'(seen), 1);
            rst = 1'b1;
            @(negedge clk);
            chk("mrst_an", an, 4'hf);
            chk("mrst_seg", seg, 7'h7f);
            chk("mrst_dp", dp, 1);
            chk("mrst_fd", fd, 0);
            @(negedge clk);
            rst = 1'b0;
            for (k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (an != 4'hf) break;
            end
            chk("rst_latency", k, 3);
            chk("rst_first_an", an, 4'b1110);
            chk("rst_first_seg", seg, GLY[15]);
        end

        // Single digit, TICK_DIV=1: random inputs, invariants.
        begin
            bit got = 1'b0;
            int since = 0, lit = 0, bad = 0, pulses = 0;
            bright1 = 2'd3;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (fd1) got = 1'b1;
            end
            chk("fd1_wait", int'(got), 1);
            for (int i = 0; i < 80; i++) begin
                v1   = 4'($urandom_range(0, 15));
                dp1  = 1'($urandom_range(0, 1));
                lzs1 = 1'($urandom_range(0, 1));
                @(negedge clk);
                since++;
                if (an1 == 1'b0) lit++;
                if (an1 && (seg1 != 7'h7f || !dpo1)) bad++;
                if (fd1) begin
                    pulses++;
                    chk("fd1_period", since, 4);
                    chk("fd1_lit", lit, 3);
                    since = 0;
                    lit = 0;
                end
            end
            chk("fd1_pulses", pulses, 20);
            chk("dark1_outputs", bad, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
